// File: rtl/adc_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : adc_capture
//  Purpose  : Conversion sequencer for a parallel-output ADC. Runs the
//             CONVST/RD/PD handshake, averages 2^AVG_LOG2 conversions per
//             request, flags EOC timeouts, powers down while unlocked.
//  Revision : 1.0  initial release
// ============================================================================
module adc_capture #(
    parameter int DATA_W     = 12,
    parameter int AVG_LOG2   = 2,
    parameter int CONVST_LOW = 2,
    parameter int RD_LOW     = 2,
    parameter int TIMEOUT    = 64,
    parameter int WAKE_CYC   = 16
) (
    input  logic              clk_10MHz,
    input  logic              reset,
    input  logic              locked,
    input  logic              start,
    input  logic              ADC_EOC,
    input  logic [DATA_W-1:0] ADC_DATA,
    output logic              ADC_CONVST,
    output logic              ADC_RD,
    output logic              ADC_PD,
    output logic              ready,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    output logic              timeout_err
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT + WAKE_CYC + CONVST_LOW + RD_LOW + 1);
    localparam int NUM_W = AVG_LOG2 + 1;

    localparam logic [NUM_W-1:0] LAST_CONV  = NUM_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] WAKE_END   = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CONVST_END = CNT_W'(CONVST_LOW - 1);
    localparam logic [CNT_W-1:0] RD_END     = CNT_W'(RD_LOW - 1);
    localparam logic [CNT_W-1:0] TMO_END    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_WAKE     = 3'd1,
        S_IDLE     = 3'd2,
        S_CONV     = 3'd3,
        S_WAIT_EOC = 3'd4,
        S_READ     = 3'd5,
        S_RELEASE  = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               eoc_meta;
    logic               eoc_s;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_W-1:0]   conv_cnt;
    logic [ACC_W-1:0]   acc;
    logic               rd_done;
    logic               clr_req;
    logic               tmo_hit;

    // Two-flop synchronizer for the asynchronous end-of-conversion input.
    always_ff @(posedge clk_10MHz) begin
        if (!reset) begin
            eoc_meta <= 1'b1;
            eoc_s    <= 1'b1;
        end else begin
            eoc_meta <= ADC_EOC;
            eoc_s    <= eoc_meta;
        end
    end

    // Next-state decode; losing lock overrides every other decision.
    always_comb begin
        state_n = state;
        clr_req = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            S_OFF:      if (locked) state_n = S_WAKE;
            S_WAKE:     if (cnt == WAKE_END) state_n = S_IDLE;
            S_IDLE: begin
                if (start && ready) begin
                    state_n = S_CONV;
                    clr_req = 1'b1;
                end
            end
            S_CONV:     if (cnt == CONVST_END) state_n = S_WAIT_EOC;
            S_WAIT_EOC: begin
                if (!eoc_s) begin
                    state_n = S_READ;
                end else if (cnt == TMO_END) begin
                    state_n = S_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            S_READ:     if (cnt == RD_END) state_n = S_RELEASE;
            S_RELEASE: begin
                if (eoc_s) begin
                    state_n = (conv_cnt == LAST_CONV) ? S_DONE : S_CONV;
                end else if (cnt == TMO_END) begin
                    state_n = S_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_OFF;
        endcase
        if (!locked) begin
            state_n = S_OFF;
            clr_req = 1'b0;
            tmo_hit = 1'b0;
        end
    end

    // State register, per-state cycle counter (zeroed on every state change),
    // conversion count and accumulator.
    always_ff @(posedge clk_10MHz) begin
        if (!reset) begin
            state    <= S_OFF;
            cnt      <= '0;
            conv_cnt <= '0;
            acc      <= '0;
            rd_done  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= (state_n != state) ? '0 : cnt + 1'b1;
            // Data is captured one edge after READ ends, on the edge RD rises.
            rd_done <= (state == S_READ) && (state_n == S_RELEASE);
            if (clr_req) begin
                conv_cnt <= '0;
                acc      <= '0;
            end else begin
                if ((state == S_RELEASE) && (state_n == S_CONV)) begin
                    conv_cnt <= conv_cnt + 1'b1;
                end
                if (rd_done) begin
                    acc <= acc + ACC_W'(ADC_DATA);
                end
            end
        end
    end

    // Registered outputs, decoded from the current state and forced safe
    // as soon as lock is lost.
    always_ff @(posedge clk_10MHz) begin
        if (!reset) begin
            ADC_CONVST   <= 1'b1;
            ADC_RD       <= 1'b1;
            ADC_PD       <= 1'b1;
            ready        <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            ADC_CONVST   <= !((state == S_CONV) && locked);
            ADC_RD       <= !((state == S_READ) && locked);
            ADC_PD       <= (state == S_OFF) || !locked;
            ready        <= (state == S_IDLE) && locked;
            sample_valid <= (state == S_DONE) && locked;
            timeout_err  <= tmo_hit;
            if ((state == S_DONE) && locked) begin
                sample_data <= DATA_W'(acc >> AVG_LOG2);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/adc_capture.md
# adc_capture

Conversion sequencer for the board's parallel-output ADC. It sits directly downstream of the top-level measurement FSM. A one-cycle `start` request from the FSM drives the ADC `CONVST`/`RD`/`PD` handshake. The block collects 2^AVG_LOG2 conversions, averages them, and returns one result word with a single-cycle valid strobe. It also reports conversion timeouts and holds the ADC powered down while the clock is not locked.

## Interface
- `DATA_W`, 12: ADC data bus width.
- `AVG_LOG2`, 2: number of conversions averaged per request is 2^AVG_LOG2; legal range 0..3.
- `CONVST_LOW`, 2: cycles `ADC_CONVST` is held low per conversion; ≥1.
- `RD_LOW`, 2: cycles `ADC_RD` is held low per read; ≥1.
- `TIMEOUT`, 64: maximum cycles spent waiting on any single EOC edge.
- `WAKE_CYC`, 16: cycles after `locked` rises before the first request is accepted.

- `clk_10MHz` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `locked` in 1: clock-generator lock indicator. Low means power down and abort.
- `start` in 1: request pulse. Accepted only when `ready`=1.
- `ADC_EOC` in 1: ADC end-of-conversion, active low. Asynchronous to `clk_10MHz`.
- `ADC_DATA` in DATA_W: ADC parallel output, valid while `ADC_RD` is low.
- `ADC_CONVST` out 1: conversion start, active low.
- `ADC_RD` out 1: read strobe, active low.
- `ADC_PD` out 1: ADC power-down, active high.
- `ready` out 1: idle, powered, and able to accept `start`.
- `sample_data` out DATA_W: averaged result. Holds its value until the next result.
- `sample_valid` out 1: one-cycle strobe; `sample_data` is new this cycle.
- `timeout_err` out 1: one-cycle strobe; the request was aborted on timeout.

## Operation
- `ADC_EOC` passes through a 2-flop synchronizer. `eoc_s` denotes the synchronized value, and all state decisions use `eoc_s` only.
- State machine:
  - OFF: `ADC_PD`=1. Exits to WAKE when `locked`=1.
  - WAKE: `ADC_PD`=0. Counts WAKE_CYC cycles, then goes to IDLE.
  - IDLE: `ready`=1. On `start`=1, clears the accumulator and the conversion count, then goes to CONV.
  - CONV: `ADC_CONVST`=0 for CONVST_LOW cycles, then goes to WAIT_EOC.
  - WAIT_EOC: waits for `eoc_s`=0, then goes to READ.
  - READ: `ADC_RD`=0 for RD_LOW cycles.
    - `ADC_DATA` is added to the accumulator on the last RD-low cycle, i.e. the edge on which `ADC_RD` returns high.
    - Then goes to RELEASE.
  - RELEASE: `ADC_RD`=1. Waits for `eoc_s`=1.
    - If count < 2^AVG_LOG2−1: increments the count and goes to CONV.
    - Otherwise: goes to DONE.
  - DONE:
    - `sample_data` ← accumulator >> AVG_LOG2. This truncates and never rounds.
    - `sample_valid` is pulsed.
    - Then goes to IDLE.
- Accumulator width is DATA_W+AVG_LOG2; no overflow is possible.
- Timeout: a counter is cleared on entry to WAIT_EOC and on entry to RELEASE. If it reaches TIMEOUT in either state:
  - `timeout_err` is pulsed for one cycle.
  - `ADC_CONVST`=`ADC_RD`=1.
  - The accumulator is discarded, with no `sample_valid` and no change to `sample_data`.
  - The state returns to IDLE.
- Abort on `locked`=0 in any state:
  - The next state is OFF.
  - `ADC_PD`=1, `ADC_CONVST`=`ADC_RD`=1, `ready`=0.
  - No `sample_valid` and no `timeout_err` are generated.
- `start` while `ready`=0 is ignored and not queued.
- `locked` falling in the same cycle as `start` or as a timeout: the abort wins.

## Timing
- Reset values:
  - Outputs: `ADC_CONVST`=1, `ADC_RD`=1, `ADC_PD`=1, `ready`=0, `sample_data`=0, `sample_valid`=0, `timeout_err`=0.
  - Internal: state=OFF, synchronizer flops=1.
- All outputs are registered.
  - `start` sampled at edge k puts `ADC_CONVST` low from edge k+1 through edge k+CONVST_LOW.
  - `ready` falls at edge k+1.
- `ADC_EOC` falling at the ADC pin is visible to the FSM 2 edges later. The READ entry decision follows on the next edge.
- Cycles per conversion with zero ADC delay = CONVST_LOW + RD_LOW + 2×(sync latency 2) + 2 (state transitions).
- `sample_valid` is high for exactly 1 cycle. `ready` returns on the edge after `sample_valid`.
- After `locked` rises: `ADC_PD` falls 1 edge later, and `ready` rises after WAKE_CYC+1 edges.

## Test plan
- Reset, then `locked`=1 → `ADC_PD` goes from 1 to 0 on the next cycle; `ready`=1 after 17 cycles; `ready` stays 0 before that.
- AVG_LOG2=2, ADC model returns 100, 101, 102, 104 with EOC low 10 cycles after `CONVST` rises → four `CONVST` pulses 2 cycles low; `sample_data`=101 (407>>2); one `sample_valid`.
- AVG_LOG2=0, data 0xFFF → `sample_data`=0xFFF, valid once; a second `start` during the busy period is ignored (only one result).
- ADC model never asserts EOC → `timeout_err` pulses once 64 cycles after WAIT_EOC entry; `sample_data` unchanged; `ready`=1 on the next cycle.
- `locked` dropped during READ → `ADC_RD`=1 and `ADC_PD`=1 next cycle; no valid and no err; after `locked` returns, a normal conversion completes.
- `reset`=0 mid-conversion → all outputs at reset values on the next edge.
